// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths, defaults and response-state type for the SRAM arbiter
package sram_pkg;

    localparam int SRAM_ADDR_W      = 16;
    localparam int DATA_W           = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } resp_state_e;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - fetch, data and SRAM port bundle for the SRAM arbiter
interface sram_arbiter_if;
    import sram_pkg::*;

    logic                   if_req;
    logic [SRAM_ADDR_W-1:0] if_addr;
    logic                   if_gnt;
    logic                   if_rvalid;
    logic [DATA_W-1:0]      if_rdata;
    logic                   if_err;

    logic                   d_req;
    logic                   d_we;
    logic [SRAM_ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0]      d_wdata;
    logic                   d_gnt;
    logic                   d_rvalid;
    logic [DATA_W-1:0]      d_rdata;
    logic                   d_err;

    logic                   sram_en;
    logic                   sram_wr;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0]      sram_wdata;
    logic [DATA_W-1:0]      sram_rdata;

    // master: requesters plus the SRAM macro
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  sram_en, sram_wr, sram_addr, sram_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output sram_en, sram_wr, sram_addr, sram_wdata
    );

endinterface

// File: rtl/sram_arb_prio.sv
// rtl/sram_arb_prio.sv - data-first priority pick with a saturating fetch starvation counter
module sram_arb_prio
    import sram_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic if_gnt_o,
    output logic d_gnt_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             starved;

    assign starved  = (starve_q == LIMIT);

    // Grants are held off while reset is asserted so nothing reaches the SRAM.
    assign if_gnt_o = !rst && if_req_i && (!d_req_i || starved);
    assign d_gnt_o  = !rst && d_req_i && !if_gnt_o;

    always_comb begin
        starve_d = '0;
        if (if_req_i && !if_gnt_o) begin
            starve_d = starved ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - single-port SRAM arbiter between instruction fetch and data access
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    logic        if_gnt;
    logic        d_gnt;
    logic        if_ok;
    logic        d_ok;
    resp_state_e state_q;
    resp_state_e state_d;
    logic        err_q;
    logic        err_d;

    sram_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .if_req_i(bus.if_req),
        .d_req_i (bus.d_req),
        .if_gnt_o(if_gnt),
        .d_gnt_o (d_gnt)
    );

    assign if_ok = is_aligned(bus.if_addr[1:0]);
    assign d_ok  = is_aligned(bus.d_addr[1:0]);

    assign bus.if_gnt     = if_gnt;
    assign bus.d_gnt      = d_gnt;
    assign bus.sram_en    = (if_gnt && if_ok) || (d_gnt && d_ok);
    assign bus.sram_wr    = d_gnt && d_ok && bus.d_we;
    assign bus.sram_addr  = d_gnt ? bus.d_addr : bus.if_addr;
    assign bus.sram_wdata = bus.d_wdata;

    // Only reads and misaligned accesses owe a response; aligned stores finish at grant.
    always_comb begin
        state_d = IDLE;
        err_d   = 1'b0;
        if (if_gnt) begin
            state_d = RESP_IF;
            err_d   = !if_ok;
        end else if (d_gnt && (!bus.d_we || !d_ok)) begin
            state_d = RESP_D;
            err_d   = !d_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign bus.if_rvalid = (state_q == RESP_IF);
    assign bus.if_err    = (state_q == RESP_IF) && err_q;
    assign bus.if_rdata  = ((state_q == RESP_IF) && !err_q) ? bus.sram_rdata : '0;

    assign bus.d_rvalid  = (state_q == RESP_D);
    assign bus.d_err     = (state_q == RESP_D) && err_q;
    assign bus.d_rdata   = ((state_q == RESP_D) && !err_q) ? bus.sram_rdata : '0;

endmodule
